// File: rtl/pipelined_control_decoder.sv
// Registered RV32I control decoder at the ID/EX boundary, with stall/flush handling.
// Build option: define RV32M_EN to enable multi-cycle MUL/DIV issue sequencing (adds the FSM and mdu_op).
module pipelined_control_decoder #(
  parameter int MDU_LATENCY  = 4,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic        write,
  output logic        store,
  output logic        load,
  output logic        branch,
  output logic [1:0]  alu_operand_a_selector,
  output logic        alu_operand_b_selector,
  output logic [1:0]  immediate_selector,
  output logic [1:0]  next_pc_selector,
  output logic [2:0]  alu_operations_selector,
  output logic [2:0]  funct3,
  output logic        mdu_op,
  output logic        illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_IA     = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       write;
    logic       store;
    logic       load;
    logic       branch;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [1:0] imm_sel;
    logic [1:0] npc_sel;
    logic [2:0] alu_op;
    logic [2:0] funct3;
    logic       mdu_op;
    logic       illegal;
  } ctrl_t;

  if (MDU_LATENCY < 1 || MDU_LATENCY > 15) begin : g_bad_mdu_latency
    $error("MDU_LATENCY must be in 1..15");
  end

  ctrl_t dec;
  logic  dec_is_m;
  logic  accept;
  ctrl_t out_q, out_d;
  logic  out_valid_q, out_valid_d;
  logic  unused_instr_bits;

  assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};

  always_comb begin
    dec        = '0;
    dec.funct3 = instruction[14:12];
    dec_is_m   = (instruction[6:0] == OP_R) && (instruction[31:25] == 7'b0000001);
    case (instruction[6:0])
      OP_R:      begin dec.write = 1'b1; dec.imm_sel = 2'b11; end
      OP_LD:     begin dec.write = 1'b1; dec.load = 1'b1; dec.b_sel = 1'b1; dec.alu_op = 3'b100; end
      OP_IA:     begin dec.write = 1'b1; dec.b_sel = 1'b1; dec.alu_op = 3'b010; end
      OP_JALR:   begin
        dec.write = 1'b1; dec.a_sel = 2'b01; dec.b_sel = 1'b1;
        dec.npc_sel = 2'b01; dec.alu_op = 3'b110;
      end
      OP_S:      begin dec.store = 1'b1; dec.b_sel = 1'b1; dec.imm_sel = 2'b10; dec.alu_op = 3'b001; end
      OP_B:      begin dec.branch = 1'b1; dec.imm_sel = 2'b11; dec.npc_sel = 2'b10; end
      OP_AUIPC:  begin
        dec.write = 1'b1; dec.a_sel = 2'b10; dec.b_sel = 1'b1;
        dec.imm_sel = 2'b01; dec.alu_op = 3'b101;
      end
      OP_LUI:    begin dec.write = 1'b1; dec.b_sel = 1'b1; dec.imm_sel = 2'b01; dec.alu_op = 3'b011; end
      OP_JAL:    begin
        dec.write = 1'b1; dec.a_sel = 2'b01; dec.imm_sel = 2'b11;
        dec.npc_sel = 2'b11; dec.alu_op = 3'b111;
      end
      OP_FENCE, OP_SYSTEM: ;
      default:   dec.illegal = 1'b1;
    endcase
`ifdef RV32M_EN
    dec.mdu_op = dec_is_m;
`else
    // Without the MDU, M-extension encodings are unsupported.
    if (dec_is_m) begin
      dec         = '0;
      dec.funct3  = instruction[14:12];
      dec.illegal = 1'b1;
    end
`endif
  end

`ifdef RV32M_EN
  typedef enum logic {IDLE, MDU_WAIT} state_t;
  localparam logic [3:0] CNT_INIT = (MDU_LATENCY > 1) ? 4'(MDU_LATENCY - 2) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      lat_q, lat_d;

  assign in_ready = ~stall & (state_q == IDLE);
`else
  assign in_ready = ~stall;
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
`ifdef RV32M_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
`endif
    if (flush) begin
      out_d       = '0;
      out_valid_d = 1'b0;
`ifdef RV32M_EN
      state_d = IDLE;
      cnt_d   = 4'd0;
`endif
    end else if (!stall) begin
      out_d       = '0;
      out_valid_d = 1'b0;
`ifdef RV32M_EN
      if (state_q == MDU_WAIT) begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_d        = lat_q;
          out_d.mdu_op = 1'b1;
          out_valid_d  = 1'b1;
          state_d      = IDLE;
        end
      end else
`endif
      if (accept && !(dec.illegal && ILLEGAL_TRAP == 0)) begin
`ifdef RV32M_EN
        if (dec.mdu_op && MDU_LATENCY > 1) begin
          lat_d   = dec;
          cnt_d   = CNT_INIT;
          state_d = MDU_WAIT;
        end else
`endif
        begin
          out_d       = dec;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef RV32M_EN
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lat_q   <= '0;
`endif
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef RV32M_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
`endif
    end
  end

  assign out_valid               = out_valid_q;
  assign write                   = out_q.write;
  assign store                   = out_q.store;
  assign load                    = out_q.load;
  assign branch                  = out_q.branch;
  assign alu_operand_a_selector  = out_q.a_sel;
  assign alu_operand_b_selector  = out_q.b_sel;
  assign immediate_selector      = out_q.imm_sel;
  assign next_pc_selector        = out_q.npc_sel;
  assign alu_operations_selector = out_q.alu_op;
  assign funct3                  = out_q.funct3;
  assign mdu_op                  = out_q.mdu_op;
  assign illegal                 = out_q.illegal;

endmodule
